// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB + saturating-counter table, bimodal or gshare indexed.
// Fetch lookup is combinational off registered tables; execute resolution updates on the clock edge.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_branch,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict_e,
  output logic [XLEN-1:0] redirect_pc_e,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int HW    = (GHR_W > 0) ? GHR_W : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [HW-1:0]      ghr_q;

  function automatic logic [IDX_W-1:0] index_of(input logic [XLEN-1:0] pc, input logic [HW-1:0] ghr);
    logic [IDX_W-1:0] hist;
    hist = '0;
    if (GHR_W > 0) hist[HW-1:0] = ghr;
    return pc[IDX_W+1:2] ^ hist;
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [XLEN-1:0] pc);
    return pc[IDX_W+2+TAG_W-1:IDX_W+2];
  endfunction

  logic [IDX_W-1:0] f_idx, u_idx;
  logic             f_hit, u_hit;
  logic             is_ctrl, eff_taken;
  logic [XLEN-1:0]  actual_next;
  logic             unused_bits;

  assign f_idx = index_of(pc_f, ghr_q);
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == tag_of(pc_f));
  assign pred_taken_f  = f_hit && (jump_q[f_idx] || cnt_q[f_idx][CNT_W-1]);
  assign pred_target_f = pred_taken_f ? target_q[f_idx] : pc_f + XLEN'(4);

  assign u_idx = index_of(upd_pc, ghr_q);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == tag_of(upd_pc));

  // A non-control instruction never really redirects, whatever upd_taken carries.
  assign is_ctrl     = upd_is_branch || upd_is_jump;
  assign eff_taken   = upd_is_jump || (upd_is_branch && upd_taken);
  assign actual_next = eff_taken ? upd_target : upd_pc + XLEN'(4);

  // Redirects are suppressed while reset is held so a flush cannot leak out of reset.
  assign mispredict_e  = reset && upd_valid && (upd_pred_target != actual_next);
  assign redirect_pc_e = actual_next;

  assign unused_bits = ^{pc_f, upd_pc, upd_pred_taken};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        jump_q[i]   <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
      ghr_q         <= '0;
      br_count      <= '0;
      mispred_count <= '0;
    end else if (upd_valid) begin
      if (is_ctrl) begin
        if (u_hit) begin
          if (eff_taken) begin
            if (cnt_q[u_idx] != CNT_MAX) cnt_q[u_idx] <= cnt_q[u_idx] + CNT_W'(1);
            target_q[u_idx] <= upd_target;
            jump_q[u_idx]   <= upd_is_jump;
          end else if (cnt_q[u_idx] != '0) begin
            cnt_q[u_idx] <= cnt_q[u_idx] - CNT_W'(1);
          end
        end else if (eff_taken) begin
          valid_q[u_idx]  <= 1'b1;
          tag_q[u_idx]    <= tag_of(upd_pc);
          target_q[u_idx] <= upd_target;
          jump_q[u_idx]   <= upd_is_jump;
          cnt_q[u_idx]    <= CNT_WT;
        end
        if (br_count != '1) br_count <= br_count + 32'd1;
        if (mispredict_e && (mispred_count != '1)) mispred_count <= mispred_count + 32'd1;
      end else if (u_hit) begin
        valid_q[u_idx] <= 1'b0;
      end
      if (upd_is_branch && (GHR_W > 0)) ghr_q <= (ghr_q << 1) | HW'(upd_taken);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: bimodal instance for table/counter behaviour,
// gshare instance (GHR_W=4) for history-based learning of an alternating branch.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_f = '0;
  logic        upd_valid = 1'b0, upd_is_branch = 1'b0, upd_is_jump = 1'b0;
  logic        upd_taken = 1'b0, upd_pred_taken = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0, upd_pred_target = '0;

  logic        b_pt, b_mp, g_pt, g_mp;
  logic [31:0] b_tgt, b_rd, b_brc, b_mpc, g_tgt, g_rd, g_brc, g_mpc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor u_bi (
    .clk(clk), .reset(reset), .pc_f(pc_f), .pred_taken_f(b_pt), .pred_target_f(b_tgt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict_e(b_mp), .redirect_pc_e(b_rd),
    .br_count(b_brc), .mispred_count(b_mpc)
  );

  branch_predictor #(.GHR_W(4)) u_gs (
    .clk(clk), .reset(reset), .pc_f(pc_f), .pred_taken_f(g_pt), .pred_target_f(g_tgt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict_e(g_mp), .redirect_pc_e(g_rd),
    .br_count(g_brc), .mispred_count(g_mpc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one resolving instruction for a cycle; returns the bimodal resolve outputs
  // and fetch prediction sampled just before the committing edge.
  task automatic resolve(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                         input logic tk, input logic [31:0] tgt, input logic [31:0] ptgt,
                         output logic mp, output logic [31:0] rd, output logic pt_pre);
    @(negedge clk);
    upd_valid = v; upd_pc = pc; upd_is_branch = br; upd_is_jump = jmp;
    upd_taken = tk; upd_target = tgt; upd_pred_target = ptgt;
    upd_pred_taken = (ptgt != pc + 32'd4);
    #1;
    mp = b_mp; rd = b_rd; pt_pre = b_pt;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  initial begin
    logic        mp, pt;
    logic [31:0] rd, gtgt, mpc_mid;
    mpc_mid = '0;

    pc_f = 32'h100;
    #2;
    check("rst_pt", b_pt, 0);
    check("rst_tgt", b_tgt, 32'h104);
    check("rst_brc", b_brc, 0);
    check("rst_mpc", b_mpc, 0);
    check("rst_gs_tgt", g_tgt, 32'h104);
    @(negedge clk); reset = 1'b1;

    // Taken branch allocates weakly-taken entry
    resolve(1, 32'h100, 1, 0, 1, 32'h80, 32'h104, mp, rd, pt);
    check("alloc_mp", mp, 1);
    check("alloc_rd", rd, 32'h80);
    check("alloc_brc", b_brc, 1);
    check("alloc_mpc", b_mpc, 1);
    pc_f = 32'h100; #1;
    check("alloc_pt", b_pt, 1);
    check("alloc_tgt", b_tgt, 32'h80);

    // 2 -> 1: now predicts not-taken
    resolve(1, 32'h100, 1, 0, 0, 32'h80, 32'h80, mp, rd, pt);
    check("nt1_mp", mp, 1);
    check("nt1_rd", rd, 32'h104);
    pc_f = 32'h100; #1;
    check("nt1_pt", b_pt, 0);
    check("nt1_tgt", b_tgt, 32'h104);

    // 1 -> 0, then hold at 0; one taken brings it to 1 (still not-taken)
    resolve(1, 32'h100, 1, 0, 0, 32'h80, 32'h104, mp, rd, pt);
    check("nt2_mp", mp, 0);
    resolve(1, 32'h100, 1, 0, 0, 32'h80, 32'h104, mp, rd, pt);
    check("nt3_mp", mp, 0);
    resolve(1, 32'h100, 1, 0, 1, 32'h80, 32'h104, mp, rd, pt);
    check("t_after_floor_mp", mp, 1);
    pc_f = 32'h100; #1;
    check("floor_hold_pt", b_pt, 0);
    check("floor_brc", b_brc, 5);
    check("floor_mpc", b_mpc, 3);

    // jal allocates; jump bit keeps it taken even after counter drains
    resolve(1, 32'h200, 0, 1, 1, 32'h400, 32'h204, mp, rd, pt);
    check("jal_mp", mp, 1);
    check("jal_rd", rd, 32'h400);
    pc_f = 32'h200; #1;
    check("jal_pt", b_pt, 1);
    check("jal_tgt", b_tgt, 32'h400);
    resolve(1, 32'h200, 1, 0, 0, 32'h400, 32'h400, mp, rd, pt);
    resolve(1, 32'h200, 1, 0, 0, 32'h400, 32'h400, mp, rd, pt);
    pc_f = 32'h200; #1;
    check("jal_drained_pt", b_pt, 1);
    check("jal_drained_tgt", b_tgt, 32'h400);
    check("jal_brc", b_brc, 8);
    check("jal_mpc", b_mpc, 6);

    // Aliasing non-control instruction (same idx/tag) invalidates entry
    resolve(1, 32'h10200, 0, 0, 0, 32'h0, 32'h400, mp, rd, pt);
    check("alias_mp", mp, 1);
    check("alias_rd", rd, 32'h10204);
    check("alias_brc", b_brc, 8);
    check("alias_mpc", b_mpc, 6);
    pc_f = 32'h200; #1;
    check("alias_pt", b_pt, 0);
    check("alias_tgt", b_tgt, 32'h204);

    // Bubble: no state change, no mispredict
    resolve(0, 32'h100, 1, 0, 1, 32'h80, 32'h104, mp, rd, pt);
    check("bubble_mp", mp, 0);
    check("bubble_brc", b_brc, 8);
    pc_f = 32'h100; #1;
    check("bubble_pt", b_pt, 0);

    // Not-taken miss does not allocate
    resolve(1, 32'h300, 1, 0, 0, 32'h900, 32'h304, mp, rd, pt);
    check("ntmiss_mp", mp, 0);
    pc_f = 32'h300; #1;
    check("ntmiss_pt", b_pt, 0);

    // Same-cycle lookup sees pre-edge contents
    pc_f = 32'h500;
    resolve(1, 32'h500, 1, 0, 1, 32'h700, 32'h504, mp, rd, pt);
    check("nobypass_pre_pt", pt, 0);
    check("nobypass_mp", mp, 1);
    check("nobypass_post_pt", b_pt, 1);
    check("nobypass_post_tgt", b_tgt, 32'h700);
    check("pre_rst_brc", b_brc, 10);
    check("pre_rst_mpc", b_mpc, 7);

    // Reset mid-cycle with a mispredicting update pending
    @(negedge clk);
    upd_valid = 1; upd_pc = 32'h100; upd_is_branch = 1; upd_is_jump = 0;
    upd_taken = 1; upd_target = 32'h80; upd_pred_target = 32'h104; upd_pred_taken = 0;
    #1;
    check("midrst_pre_mp", b_mp, 1);
    reset = 1'b0;
    #1;
    check("midrst_mp", b_mp, 0);
    check("midrst_brc", b_brc, 0);
    check("midrst_mpc", b_mpc, 0);
    pc_f = 32'h500; #1;
    check("midrst_pt", b_pt, 0);
    check("midrst_tgt", b_tgt, 32'h504);
    upd_valid = 0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    pc_f = 32'h100; #1;
    check("postrst_pt", b_pt, 0);
    check("postrst_brc", b_brc, 0);

    // gshare: alternating T/NT branch at 0x600
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      pc_f = 32'h600;
      #1;
      gtgt = g_tgt;
      resolve(1, 32'h600, 1, 0, (k % 2 == 0), 32'h640, gtgt, mp, rd, pt);
      if (k == 7) mpc_mid = g_mpc;
    end
    check("gs_brc", g_brc, 16);
    check("gs_mpc_total", g_mpc, 3);
    check("gs_mpc_last8", g_mpc - mpc_mid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage pipelined core. Replaces static not-taken fetch, where PCSrcE alone redirects the PC.
- Fetch-stage lookup is combinational and reads registered BTB/BHT tables. It returns predicted next PC and taken flag.
- Execute-stage resolution updates the tables on the clock edge and flags mispredicts. Hazard logic uses the mispredict flag to flush D/E and redirect fetch.
- Supports bimodal or gshare indexing, configurable depth, tag width and counter width, plus performance counters.

Parameters:
XLEN, 32, address/data width
ENTRIES, 64, table depth; power of 2, >=4; IDX_W = log2(ENTRIES)
TAG_W, 8, BTB tag bits taken from PC above index
CNT_W, 2, saturating-counter width (>=1)
GHR_W, 0, global-history bits; 0 = bimodal, >0 = gshare (GHR_W <= IDX_W)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
pc_f  input  XLEN  fetch PC
pred_taken_f  output  1  predict redirect
pred_target_f  output  XLEN  predicted next PC
upd_valid  input  1  valid (non-bubble) instruction resolving in E
upd_pc  input  XLEN  PC of resolving instruction
upd_is_branch  input  1  conditional branch
upd_is_jump  input  1  unconditional jump/jal
upd_taken  input  1  actual outcome (forced 1 when upd_is_jump)
upd_target  input  XLEN  actual taken target
upd_pred_taken  input  1  prediction carried down the pipe with the instruction
upd_pred_target  input  XLEN  predicted next PC carried down the pipe
mispredict_e  output  1  prediction wrong; flush D/E
redirect_pc_e  output  XLEN  correct next PC
br_count  output  32  resolved branches+jumps
mispred_count  output  32  mispredicts

Behaviour:
- Reset (reset=0, async):
  - all valid bits=0; counters=2^(CNT_W-1)-1 (weakly not-taken); GHR=0; br_count=mispred_count=0.
  - Outputs then give pred_taken_f=0 and pred_target_f=pc_f+4.
- Index and tag:
  - idx = pc[IDX_W+1:2], XOR with {0, GHR} when GHR_W>0.
  - tag = pc[IDX_W+2+TAG_W-1:IDX_W+2].
  - The same function is used for lookup and update, with the GHR value current at that cycle.
- Lookup (combinational):
  - hit = valid[idx] & tag match.
  - pred_taken_f = hit & (jump[idx] | counter[idx] MSB).
  - pred_target_f = pred_taken_f ? target[idx] : pc_f+4.
- Resolve (combinational):
  - actual_next = (upd_taken|upd_is_jump) ? upd_target : upd_pc+4.
  - mispredict_e = upd_valid & (upd_pred_target != actual_next).
  - redirect_pc_e = actual_next.
  - A non-control instruction predicted taken (alias) mispredicts with redirect upd_pc+4.
- Update (posedge, only when upd_valid):
  - Branch/jump, tag hit: counter saturating +1 if taken, else -1; never wraps past 0 or 2^CNT_W-1. If taken, target updated; jump bit = upd_is_jump.
  - Branch/jump, tag miss: allocate only if taken, with tag, target, jump bit, counter=2^(CNT_W-1) (weakly taken). A not-taken miss leaves the entry untouched.
  - Non-control instruction with tag hit: valid cleared.
  - Conditional branch with GHR_W>0: GHR <= {GHR[GHR_W-2:0], upd_taken}. History is updated at resolve, non-speculatively.
- Counters, when upd_valid & (branch|jump):
  - br_count +1.
  - mispred_count +1 when mispredict_e is also set.
  - Both saturate at 32'hFFFFFFFF.
- Same-index lookup and update in one cycle: lookup returns the pre-edge contents; no bypass.
- upd_valid=0 (bubble/flush): no state change; mispredict_e=0.
- Reset asserted mid-operation clears state immediately. A redirect pending in that cycle is dropped.

Test Plan:
- Reset, then pc_f=0x100 -> pred_taken_f=0, pred_target_f=0x104, counters 0.
- Resolve taken branch upd_pc=0x100, target 0x80, upd_pred_target=0x104 -> mispredict_e=1, redirect 0x80, mispred_count=1. Next cycle pc_f=0x100 -> pred_taken_f=1, target 0x80.
- Same branch resolved not-taken twice (CNT_W=2): counter 2->1->0. Lookup predicts not-taken after the first resolve. Counter holds at 0 on a third not-taken.
- jal at 0x200 -> 0x400 allocated -> predicted taken regardless of counter. Non-control instruction at an aliasing PC with same tag resolves with pred_taken=1 -> mispredict, redirect upd_pc+4, entry invalidated.
- GHR_W=4: branches at the same PC with history 0000 vs 0101 train distinct entries; taken/not-taken alternation learned after warm-up, with 0 mispredicts over the last 8 iterations.
- Assert reset mid-stream with valid entries and counters nonzero -> all lookups not-taken, counts 0. Update with upd_valid=0 leaves the tables unchanged.
